// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared frame geometry, opcodes and state type for the SPI initiator
package spi_pkg;

  localparam int SPI_FRAME_W = 44;
  localparam int SPI_OP_W    = 2;
  localparam int SPI_ADDR_W  = 10;
  localparam int SPI_DATA_W  = 32;
  localparam int SPI_HDR_W   = 12;

  localparam logic [SPI_OP_W-1:0] OP_READ  = 2'b00;
  localparam logic [SPI_OP_W-1:0] OP_WRITE = 2'b01;

  localparam int OP_LSB   = 42;
  localparam int ADDR_LSB = 32;

  // Rise numbers within one frame, counted from 1
  localparam logic [6:0] TX_BITS       = 7'd44;
  localparam logic [6:0] TURN_RISE     = 7'd45;
  localparam logic [6:0] RX_FIRST_RISE = 7'd46;
  localparam logic [6:0] RX_LAST_RISE  = 7'd89;
  localparam logic [6:0] FRAME_RISES   = 7'd90;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_TURN,
    ST_RX,
    ST_END,
    ST_GAP
  } spi_main_state_t;

  function automatic logic [SPI_FRAME_W-1:0] spi_pack_frame(
    input logic [SPI_OP_W-1:0]   op,
    input logic [SPI_ADDR_W-1:0] addr,
    input logic [SPI_DATA_W-1:0] data
  );
    return {op, addr, data};
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - sclk divider; strobes flag the clk edge on which sclk rises or falls
module spi_sclk_gen #(
  parameter int HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic          sclk_q;
  logic          tick;

  // Strobes are combinational so the caller acts on the same edge that moves sclk
  assign tick       = en_i && (cnt_q == CNT_LAST);
  assign rise_stb_o = tick && !sclk_q;
  assign fall_stb_o = tick && sclk_q;
  assign sclk_o     = sclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (tick) begin
      cnt_q  <= '0;
      sclk_q <= !sclk_q;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_main.sv
// rtl/spi_main.sv - SPI initiator: one 44-bit request frame out, one 44-bit reply frame back
module spi_main
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 2,
  parameter int GAP_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [9:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [43:0] resp_data,
  output logic        resp_hdr_err,
  output logic        busy,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso
);

  localparam int GAP_RAW = 2 * HALF_PERIOD * GAP_CYCLES;
  localparam int GAP_LEN = (GAP_RAW < 1) ? 1 : GAP_RAW;
  localparam logic [15:0] GAP_LAST = 16'(GAP_LEN - 1);

  spi_main_state_t        state_q;
  logic [6:0]             rise_cnt_q;
  logic [SPI_FRAME_W-1:0] tx_shift_q;
  logic [SPI_FRAME_W-1:0] rx_shift_q;
  logic [SPI_HDR_W-1:0]   hdr_q;
  logic [15:0]            gap_cnt_q;
  logic                   req_ready_q;
  logic                   busy_q;
  logic                   resp_valid_q;
  logic                   resp_hdr_err_q;
  logic [SPI_FRAME_W-1:0] resp_data_q;
  logic                   cs_n_q;
  logic                   mosi_q;
  logic                   sclk_en;
  logic                   rise_stb;
  logic                   fall_stb;
  logic [SPI_FRAME_W-1:0] req_frame;

  assign req_frame = spi_pack_frame(req_op, req_addr, req_wdata);
  assign sclk_en   = (state_q == ST_TX) || (state_q == ST_TURN) ||
                     (state_q == ST_RX) || (state_q == ST_END);

  spi_sclk_gen #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_sclk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (sclk_en),
    .sclk_o     (sclk),
    .rise_stb_o (rise_stb),
    .fall_stb_o (fall_stb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      rise_cnt_q     <= '0;
      tx_shift_q     <= '0;
      rx_shift_q     <= '0;
      hdr_q          <= '0;
      gap_cnt_q      <= '0;
      req_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_hdr_err_q <= 1'b0;
      resp_data_q    <= '0;
      cs_n_q         <= 1'b1;
      mosi_q         <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      if (rise_stb) begin
        rise_cnt_q <= rise_cnt_q + 7'd1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            tx_shift_q  <= req_frame;
            hdr_q       <= req_frame[SPI_FRAME_W-1:ADDR_LSB];
            rx_shift_q  <= '0;
            mosi_q      <= req_frame[SPI_FRAME_W-1];
            cs_n_q      <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            rise_cnt_q  <= '0;
            state_q     <= ST_TX;
          end
        end
        ST_TX: begin
          // At fall k the counter already holds k, so the next bit is tx_shift_q[42]
          if (fall_stb) begin
            if (rise_cnt_q == TX_BITS) begin
              mosi_q  <= 1'b0;
              state_q <= ST_TURN;
            end else begin
              tx_shift_q <= tx_shift_q << 1;
              mosi_q     <= tx_shift_q[SPI_FRAME_W-2];
            end
          end
        end
        ST_TURN: begin
          if (fall_stb && rise_cnt_q == TURN_RISE) begin
            state_q <= ST_RX;
          end
        end
        ST_RX: begin
          if (rise_stb) begin
            rx_shift_q <= {rx_shift_q[SPI_FRAME_W-2:0], miso};
            if (rise_cnt_q == RX_LAST_RISE - 7'd1) begin
              state_q <= ST_END;
            end
          end
        end
        ST_END: begin
          if (fall_stb && rise_cnt_q == FRAME_RISES) begin
            cs_n_q         <= 1'b1;
            resp_data_q    <= rx_shift_q;
            resp_hdr_err_q <= (rx_shift_q[SPI_FRAME_W-1:ADDR_LSB] != hdr_q);
            resp_valid_q   <= 1'b1;
            gap_cnt_q      <= '0;
            state_q        <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign busy         = busy_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_hdr_err = resp_hdr_err_q;
  assign cs_n         = cs_n_q;
  assign mosi         = mosi_q;

endmodule
